// File: rtl/oc_guard_if.sv
// Signal bundle between the switch/enable logic and the overcurrent guard.
// The master side drives flags, requests and clear; the slave side (oc_guard) returns enables and status.
interface oc_guard_if;
   logic [1:0] oc_in;
   logic [1:0] en_req;
   logic       clr;
   logic [1:0] en_out;
   logic [1:0] fault;
   logic [1:0] lockout;
   logic [3:0] fault_cnt0;
   logic [3:0] fault_cnt1;

   modport master (
      output oc_in, en_req, clr,
      input  en_out, fault, lockout, fault_cnt0, fault_cnt1
   );

   modport slave (
      input  oc_in, en_req, clr,
      output en_out, fault, lockout, fault_cnt0, fault_cnt1
   );
endinterface

// File: rtl/oc_guard.sv
// Two-channel H-bridge overcurrent guard: sync + filter OC flags, gate enables, retry with cooldown, lockout.
// Optional macro OC_GUARD_CROSS_TRIP_EN: a trip on one channel also forces the other channel into cooldown.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | bridge enable follows en_req; filtered OC evaluated for trip
// ST_COOL  | enable forced off, timer runs; retry when expired and OC clear
// ST_LOCK  | enable forced off until clr
module oc_guard #(
   parameter int unsigned FILTER_CYCLES   = 1000,
   parameter int unsigned COOLDOWN_CYCLES = 50000000,
   parameter int unsigned MAX_RETRIES     = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   oc_guard_if.slave  bus
);

   localparam int FW = $clog2(FILTER_CYCLES + 1);
   localparam int TW = $clog2(COOLDOWN_CYCLES + 1);

   localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);
   localparam logic [FW-1:0] F_SAT  = FW'(FILTER_CYCLES);
   localparam logic [FW-1:0] F_ONE  = FW'(1);
   localparam logic [TW-1:0] T_LAST = TW'(COOLDOWN_CYCLES - 1);
   localparam logic [TW-1:0] T_DONE = TW'(COOLDOWN_CYCLES);
   localparam logic [TW-1:0] T_ONE  = TW'(1);
   localparam logic [4:0]    R_MAX  = 5'(MAX_RETRIES);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_COOL = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   state_t          state     [2];
   logic [FW-1:0]   filt      [2];
   logic [TW-1:0]   timer     [2];
   logic [3:0]      retry     [2];
   logic [4:0]      retry_nxt [2];
   logic [3:0]      fcnt      [2];
   logic [1:0]      sync1;
   logic [1:0]      oc_s;
   logic [1:0]      trip;
   logic [1:0]      cross_trip;

   always_comb begin
      trip = 2'b00;
      for (int i = 0; i < 2; i++) begin
         trip[i]      = (state[i] == ST_RUN) && oc_s[i] && (filt[i] == F_LAST);
         retry_nxt[i] = {1'b0, retry[i]} + 5'd1;
      end
   end

`ifdef OC_GUARD_CROSS_TRIP_EN
   assign cross_trip = {trip[0], trip[1]};
`else
   assign cross_trip = 2'b00;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 2'b00;
         oc_s  <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            state[i] <= ST_RUN;
            filt[i]  <= '0;
            timer[i] <= '0;
            retry[i] <= 4'd0;
            fcnt[i]  <= 4'd0;
         end
      end else begin
         sync1 <= bus.oc_in;
         oc_s  <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (bus.clr) begin
               state[i] <= ST_RUN;
               filt[i]  <= '0;
               timer[i] <= '0;
               retry[i] <= 4'd0;
               fcnt[i]  <= 4'd0;
            end else begin
               // filter keeps counting in every state; only RUN acts on it
               if (!oc_s[i])
                  filt[i] <= '0;
               else if (filt[i] != F_SAT)
                  filt[i] <= filt[i] + F_ONE;

               case (state[i])
                  ST_RUN: begin
                     if (trip[i]) begin
                        retry[i] <= retry_nxt[i][3:0];
                        timer[i] <= '0;
                        if (fcnt[i] != 4'hF)
                           fcnt[i] <= fcnt[i] + 4'd1;
                        state[i] <= (retry_nxt[i] >= R_MAX) ? ST_LOCK : ST_COOL;
                     end else if (cross_trip[i]) begin
                        state[i] <= ST_COOL;
                        timer[i] <= '0;
                     end else if (timer[i] == T_LAST) begin
                        timer[i] <= T_DONE;
                        retry[i] <= 4'd0;
                     end else if (timer[i] != T_DONE) begin
                        timer[i] <= timer[i] + T_ONE;
                     end
                  end
                  ST_COOL: begin
                     if (timer[i] == T_LAST) begin
                        timer[i] <= '0;
                        if (!oc_s[i])
                           state[i] <= ST_RUN;
                     end else begin
                        timer[i] <= timer[i] + T_ONE;
                     end
                  end
                  ST_LOCK: state[i] <= ST_LOCK;
                  default: state[i] <= ST_RUN;
               endcase
            end
         end
      end
   end

   always_comb begin
      bus.en_out  = 2'b00;
      bus.fault   = 2'b00;
      bus.lockout = 2'b00;
      for (int i = 0; i < 2; i++) begin
         bus.en_out[i]  = bus.en_req[i] && (state[i] == ST_RUN);
         bus.fault[i]   = (state[i] == ST_COOL) || (state[i] == ST_LOCK);
         bus.lockout[i] = (state[i] == ST_LOCK);
      end
   end

   assign bus.fault_cnt0 = fcnt[0];
   assign bus.fault_cnt1 = fcnt[1];

endmodule

// File: tb/tb_oc_guard.sv
// Directed bench for oc_guard with FILTER_CYCLES=4, COOLDOWN_CYCLES=20, MAX_RETRIES=3.
// Honours OC_GUARD_CROSS_TRIP_EN when the same macro is defined for the build.
module tb_oc_guard;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   oc_guard_if bus ();

   oc_guard #(
      .FILTER_CYCLES   (4),
      .COOLDOWN_CYCLES (20),
      .MAX_RETRIES     (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      bus.oc_in  = 2'b00;
      bus.clr    = 1'b0;
      #3;
      chk("rst_fault", {6'd0, bus.fault}, 8'h00);
      chk("rst_lockout", {6'd0, bus.lockout}, 8'h00);
      chk("rst_cnt0", {4'd0, bus.fault_cnt0}, 8'h00);
      chk("rst_cnt1", {4'd0, bus.fault_cnt1}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // oc_in high for six sampling edges: trip lands on the sixth (edge 5)
   task automatic pulse(input int ch);
      bus.oc_in[ch] = 1'b1;
      repeat (6) tick();
      bus.oc_in[ch] = 1'b0;
   endtask

   task automatic lock_ch0();
      pulse(0);
      repeat (22) tick();
      pulse(0);
      repeat (22) tick();
      pulse(0);
   endtask

   logic seen;

   initial begin
      checks     = 0;
      errors     = 0;
      bus.en_req = 2'b00;
      bus.oc_in  = 2'b00;
      bus.clr    = 1'b0;
      rst_n      = 1'b0;
      #1;
      chk("rst_en_out", {6'd0, bus.en_out}, 8'h00);
      do_reset();
      chk("idle_en_out", {6'd0, bus.en_out}, 8'h00);

      bus.en_req = 2'b01;
      #1;
      chk("en_req_direct", {6'd0, bus.en_out}, 8'h01);
      bus.en_req = 2'b11;
      #1;
      chk("en_req_both", {6'd0, bus.en_out}, 8'h03);

      // glitch rejection
      bus.oc_in[0] = 1'b1;
      repeat (3) tick();
      bus.oc_in[0] = 1'b0;
      repeat (6) tick();
      chk("glitch_en", {6'd0, bus.en_out}, 8'h03);
      chk("glitch_fault", {6'd0, bus.fault}, 8'h00);
      chk("glitch_cnt0", {4'd0, bus.fault_cnt0}, 8'h00);

      // single trip, exact latency and cooldown length
      bus.oc_in[0] = 1'b1;
      repeat (5) tick();
      chk("trip_edge4_en", {6'd0, bus.en_out}, 8'h03);
      tick();
      chk("trip_edge5_en", {6'd0, bus.en_out}, 8'h02);
      chk("trip_fault", {6'd0, bus.fault}, 8'h01);
      chk("trip_cnt0", {4'd0, bus.fault_cnt0}, 8'h01);
      repeat (4) tick();
      bus.oc_in[0] = 1'b0;
      repeat (15) tick();
      chk("cool_edge24_en", {6'd0, bus.en_out}, 8'h02);
      tick();
      chk("cool_edge25_en", {6'd0, bus.en_out}, 8'h03);
      chk("cool_done_fault", {6'd0, bus.fault}, 8'h00);

      // sustained fault keeps re-arming cooldown without counting
      do_reset();
      bus.oc_in[0] = 1'b1;
      repeat (6) tick();
      seen = 1'b0;
      repeat (70) begin
         tick();
         if (bus.en_out[0]) seen = 1'b1;
      end
      chk("sust_en0_seen", {7'd0, seen}, 8'h00);
      chk("sust_cnt0", {4'd0, bus.fault_cnt0}, 8'h01);
      chk("sust_fault", {6'd0, bus.fault}, 8'h01);
      chk("sust_lockout", {6'd0, bus.lockout}, 8'h00);
      bus.oc_in[0] = 1'b0;

      // lockout after three close trips, then clr
      do_reset();
      lock_ch0();
      chk("lock_lockout", {6'd0, bus.lockout}, 8'h01);
      chk("lock_cnt0", {4'd0, bus.fault_cnt0}, 8'h03);
      seen = 1'b0;
      repeat (100) begin
         tick();
         if (bus.en_out[0]) seen = 1'b1;
      end
      chk("lock_en0_seen", {7'd0, seen}, 8'h00);
      chk("lock_en1", {7'd0, bus.en_out[1]}, 8'h01);
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      chk("clr_en_out", {6'd0, bus.en_out}, 8'h03);
      chk("clr_cnt0", {4'd0, bus.fault_cnt0}, 8'h00);
      chk("clr_lockout", {6'd0, bus.lockout}, 8'h00);

      // clr wins over a trip on the same edge
      bus.oc_in[0] = 1'b1;
      repeat (5) tick();
      bus.clr      = 1'b1;
      bus.oc_in[0] = 1'b0;
      tick();
      bus.clr = 1'b0;
      chk("clr_ovr_fault", {6'd0, bus.fault}, 8'h00);
      chk("clr_ovr_cnt0", {4'd0, bus.fault_cnt0}, 8'h00);
      repeat (8) tick();
      chk("clr_ovr_after", {6'd0, bus.en_out}, 8'h03);

      // retry count decays after a full healthy window
      do_reset();
      pulse(0);
      repeat (20) tick();
      pulse(0);
      repeat (20) tick();
      repeat (25) tick();
      pulse(0);
      chk("decay_fault", {6'd0, bus.fault}, 8'h01);
      chk("decay_lockout", {6'd0, bus.lockout}, 8'h00);
      chk("decay_cnt0", {4'd0, bus.fault_cnt0}, 8'h03);
      repeat (20) tick();
      chk("decay_recover", {6'd0, bus.en_out}, 8'h03);

      // asynchronous reset in the middle of lockout
      do_reset();
      lock_ch0();
      chk("pre_rst_lock", {6'd0, bus.lockout}, 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_lockout", {6'd0, bus.lockout}, 8'h00);
      chk("arst_en_out", {6'd0, bus.en_out}, 8'h03);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // channel-1 trip: independent or cross-tripping depending on build
      pulse(1);
      chk("ch1_cnt1", {4'd0, bus.fault_cnt1}, 8'h01);
      chk("ch1_cnt0", {4'd0, bus.fault_cnt0}, 8'h00);
`ifdef OC_GUARD_CROSS_TRIP_EN
      chk("ch1_fault", {6'd0, bus.fault}, 8'h03);
      chk("ch1_en_out", {6'd0, bus.en_out}, 8'h00);
`else
      chk("ch1_fault", {6'd0, bus.fault}, 8'h02);
      chk("ch1_en_out", {6'd0, bus.en_out}, 8'h01);
`endif
      repeat (20) tick();
      chk("ch1_recover", {6'd0, bus.en_out}, 8'h03);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
